// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST Wishbone initiator.
package mem_bist_pkg;
  typedef enum logic [2:0] {IDLE, W_STB, W_GAP, R_STB, R_GAP, FIN} state_t;
  localparam int WORD_STRIDE = 2;
  localparam int BYTE_STRIDE = 1;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/mem_bist_if.sv
// Wishbone bus between the BIST initiator and the memory controller.
interface mem_bist_if;
  logic [19:0] adr_o;
  logic [15:0] dat_o;
  logic [15:0] dat_i;
  logic        we_o;
  logic        stb_o;
  logic        byte_o;
  logic        ack_i;

  modport master (output adr_o, dat_o, we_o, stb_o, byte_o, input dat_i, ack_i);
  modport slave  (input adr_o, dat_o, we_o, stb_o, byte_o, output dat_i, ack_i);
endinterface

// File: rtl/mem_bist_pat.sv
// Combinational pattern generator: index -> bus address, write data and expected readback.
module mem_bist_pat
  import mem_bist_pkg::*;
(
  input  logic [19:0] base,
  input  logic [15:0] seed,
  input  logic        byte_mode,
  input  logic [15:0] idx,
  output logic [19:0] adr,
  output logic [15:0] wdat,
  output logic [15:0] exp_dat
);
  logic [19:0] base_eff, ofs;
  logic [7:0]  b;

  always_comb begin
    b = seed[7:0] + idx[7:0];
    if (byte_mode) begin
      base_eff = base;
      ofs      = {4'h0, idx} * 20'(BYTE_STRIDE);
      wdat     = {8'h00, b};
      // byte reads come back sign-extended from the slave
      exp_dat  = {{8{b[7]}}, b};
    end else begin
      base_eff = {base[19:1], 1'b0};
      ofs      = {4'h0, idx} * 20'(WORD_STRIDE);
      wdat     = seed + idx;
      exp_dat  = seed + idx;
    end
    adr = base_eff + ofs;
  end
endmodule

// File: rtl/mem_bist.sv
// Memory BIST initiator: write an incrementing pattern over a range, read it back, report mismatches.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [19:0] base_i,
  input  logic [15:0] len_i,
  input  logic        byte_mode_i,
  input  logic [15:0] seed_i,
  mem_bist_if.master  wb,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic        aborted_o,
  output logic [15:0] err_cnt_o,
  output logic [19:0] fail_adr_o,
  output logic [15:0] fail_exp_o,
  output logic [15:0] fail_got_o
);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [19:0] base_q, p_base, p_adr;
  logic [15:0] len_q, seed_q, idx, exp_q, tmo_cnt;
  logic [15:0] p_seed, p_idx, p_wdat, p_exp;
  logic        mode_q, p_mode, last;

  assign last = (idx == len_q - 16'd1);

  // While idle the generator sees the raw inputs so access 0 launches on the start edge.
  always_comb begin
    p_base = base_q;
    p_seed = seed_q;
    p_mode = mode_q;
    p_idx  = idx + 16'd1;
    if (state == IDLE) begin
      p_base = base_i;
      p_seed = seed_i;
      p_mode = byte_mode_i;
      p_idx  = '0;
    end else if (state == W_GAP && last) begin
      p_idx  = '0;
    end
  end

  mem_bist_pat u_pat (
    .base(p_base), .seed(p_seed), .byte_mode(p_mode), .idx(p_idx),
    .adr(p_adr), .wdat(p_wdat), .exp_dat(p_exp)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      seed_q     <= '0;
      mode_q     <= 1'b0;
      idx        <= '0;
      exp_q      <= '0;
      tmo_cnt    <= '0;
      wb.adr_o   <= '0;
      wb.dat_o   <= '0;
      wb.we_o    <= 1'b0;
      wb.stb_o   <= 1'b0;
      wb.byte_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      fail_o     <= 1'b0;
      timeout_o  <= 1'b0;
      aborted_o  <= 1'b0;
      err_cnt_o  <= '0;
      fail_adr_o <= '0;
      fail_exp_o <= '0;
      fail_got_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          base_q     <= base_i;
          len_q      <= len_i;
          seed_q     <= seed_i;
          mode_q     <= byte_mode_i;
          idx        <= '0;
          tmo_cnt    <= '0;
          busy_o     <= 1'b1;
          done_o     <= 1'b0;
          fail_o     <= 1'b0;
          timeout_o  <= 1'b0;
          aborted_o  <= 1'b0;
          err_cnt_o  <= '0;
          fail_adr_o <= '0;
          fail_exp_o <= '0;
          fail_got_o <= '0;
          wb.byte_o  <= byte_mode_i;
          if (len_i == 16'd0) begin
            state <= FIN;
          end else begin
            state    <= W_STB;
            wb.stb_o <= 1'b1;
            wb.we_o  <= 1'b1;
            wb.adr_o <= p_adr;
            wb.dat_o <= p_wdat;
          end
        end
        W_STB, R_STB: begin
          if (wb.ack_i) begin
            wb.stb_o <= 1'b0;
            state    <= (state == W_STB) ? W_GAP : R_GAP;
            if (state == R_STB && wb.dat_i != exp_q) begin
              if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
              if (!fail_o) begin
                fail_o     <= 1'b1;
                fail_adr_o <= wb.adr_o;
                fail_exp_o <= exp_q;
                fail_got_o <= wb.dat_i;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            wb.stb_o  <= 1'b0;
            timeout_o <= 1'b1;
            state     <= FIN;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        W_GAP: begin
          if (stop_i) begin
            aborted_o <= 1'b1;
            state     <= FIN;
          end else begin
            idx      <= p_idx;
            tmo_cnt  <= '0;
            wb.stb_o <= 1'b1;
            wb.adr_o <= p_adr;
            if (last) begin
              wb.we_o <= 1'b0;
              exp_q   <= p_exp;
              state   <= R_STB;
            end else begin
              wb.dat_o <= p_wdat;
              state    <= W_STB;
            end
          end
        end
        R_GAP: begin
          if (stop_i) begin
            aborted_o <= 1'b1;
            state     <= FIN;
          end else if (last) begin
            state <= FIN;
          end else begin
            idx      <= p_idx;
            tmo_cnt  <= '0;
            wb.stb_o <= 1'b1;
            wb.adr_o <= p_adr;
            exp_q    <= p_exp;
            state    <= R_STB;
          end
        end
        FIN: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          wb.we_o <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bist.sv
// Randomized bench for mem_bist with a memory-backed Wishbone responder and a spec-level pattern model.
module tb_mem_bist;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, bm = 1'b0;
  logic [19:0] base = '0;
  logic [15:0] len = '0, seed = '0;
  logic        busy, done, fail, tmo, aborted;
  logic [15:0] err_cnt, fail_exp, fail_got;
  logic [19:0] fail_adr;

  mem_bist_if bus ();

  mem_bist #(.TIMEOUT(255)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .base_i(base),
    .len_i(len), .byte_mode_i(bm), .seed_i(seed), .wb(bus),
    .busy_o(busy), .done_o(done), .fail_o(fail), .timeout_o(tmo), .aborted_o(aborted),
    .err_cnt_o(err_cnt), .fail_adr_o(fail_adr), .fail_exp_o(fail_exp), .fail_got_o(fail_got)
  );

  always #5 clk = ~clk;

  wire [111:0] all_out = {busy, done, fail, tmo, aborted, err_cnt, fail_adr, fail_exp, fail_got,
                          bus.adr_o, bus.dat_o, bus.we_o, bus.stb_o, bus.byte_o};

  typedef struct {logic we; logic [19:0] adr; logic [15:0] dat; logic bm;} txn_t;
  txn_t        log_q[$];
  logic [15:0] mem [logic [19:0]];
  int  run_id = 0, lat_max = 0, corrupt_rd = -1;
  bit  silent = 1'b0;
  int  n_checks = 0, n_pass = 0;
  int  stb_rises = 0, gap_bad = 0, unstable = 0, hi_max = 0;

  // reference model: address/data straight from the range and pattern rules
  function automatic logic [19:0] m_adr(logic [19:0] b, logic m, int i);
    longint a;
    a = m ? longint'(b) + i : longint'(b & 20'hFFFFE) + 2 * i;
    return a[19:0];
  endfunction
  function automatic logic [15:0] m_wdat(logic [15:0] s, logic m, int i);
    int v;
    v = m ? (int'(s[7:0]) + i) % 256 : (int'(s) + i) % 65536;
    return v[15:0];
  endfunction
  function automatic logic [15:0] m_rexp(logic [15:0] s, logic m, int i);
    logic [15:0] w;
    w = m_wdat(s, m, i);
    return m ? {{8{w[7]}}, w[7:0]} : w;
  endfunction

  // slave: random ack latency, byte-addressed store, byte reads sign-extended
  initial begin : responder
    int my_id, wcnt, lat, rd_cnt;
    txn_t t;
    logic [15:0] d;
    my_id = 0; wcnt = 0; lat = 0; rd_cnt = 0;
    bus.ack_i = 1'b0; bus.dat_i = '0;
    forever begin
      @(negedge clk);
      if (run_id != my_id) begin
        my_id = run_id; log_q.delete(); mem.delete(); rd_cnt = 0; wcnt = 0;
        lat = $urandom_range(lat_max, 0);
      end
      if (!rst_n) begin
        bus.ack_i = 1'b0; wcnt = 0;
      end else if (bus.ack_i) begin
        bus.ack_i = 1'b0; wcnt = 0; lat = $urandom_range(lat_max, 0);
      end else if (bus.stb_o && !silent) begin
        if (wcnt >= lat) begin
          t.we = bus.we_o; t.adr = bus.adr_o; t.bm = bus.byte_o;
          if (bus.we_o) begin
            t.dat = bus.dat_o; mem[bus.adr_o] = bus.dat_o;
          end else begin
            d = mem.exists(bus.adr_o) ? mem[bus.adr_o] : 16'h0;
            if (bus.byte_o) d = {{8{d[7]}}, d[7:0]};
            if (rd_cnt == corrupt_rd) d = 16'h0;
            rd_cnt++;
            t.dat = d; bus.dat_i = d;
          end
          log_q.push_back(t);
          bus.ack_i = 1'b1;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // strobe shape monitor: gap length, window stability, longest high run
  initial begin : monitor
    int my_id, hi, lo;
    bit seen, pstb;
    logic [53:0] pbus;
    my_id = 0; hi = 0; lo = 0; seen = 0; pstb = 0; pbus = '0;
    forever begin
      @(negedge clk);
      if (run_id != my_id) begin
        my_id = run_id; stb_rises = 0; gap_bad = 0; unstable = 0; hi_max = 0;
        hi = 0; lo = 0; seen = 0;
      end
      if (bus.stb_o) begin
        if (pstb) begin
          if (pbus !== {bus.adr_o, bus.dat_o, bus.we_o, bus.stb_o, bus.byte_o}) unstable++;
        end else begin
          stb_rises++;
          if (seen && lo != 1) gap_bad++;
        end
        seen = 1; lo = 0; hi++;
        if (hi > hi_max) hi_max = hi;
      end else begin
        hi = 0;
        if (busy) lo++;
      end
      pstb = bus.stb_o;
      pbus = {bus.adr_o, bus.dat_o, bus.we_o, bus.stb_o, bus.byte_o};
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic kick(input logic [19:0] b, input logic [15:0] l, input logic m, input logic [15:0] s);
    run_id++;
    @(negedge clk);
    base = b; len = l; bm = m; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (all_out !== '0) $display("FAIL idle_outputs: got %h want 0", all_out); else n_pass++;
  endtask

  task automatic test_word_pass;
    bit ok; int bad;
    lat_max = 2; corrupt_rd = -1;
    kick(20'h01000, 16'd4, 1'b0, 16'hA5A5);
    n_checks++; if ({busy, bus.stb_o} !== 2'b11) $display("FAIL start_latency: busy,stb=%b want 11", {busy, bus.stb_o}); else n_pass++;
    wait_done(200, ok);
    n_checks++; if (!ok) $display("FAIL word_done: done never rose"); else n_pass++;
    n_checks++; if (log_q.size() !== 8) $display("FAIL word_count: got %0d want 8", log_q.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < log_q.size() && i < 8; i++) begin
      if (log_q[i].we !== (i < 4) || log_q[i].adr !== m_adr(20'h01000, 1'b0, i % 4) ||
          log_q[i].dat !== ((i < 4) ? m_wdat(16'hA5A5, 1'b0, i) : m_rexp(16'hA5A5, 1'b0, i - 4))) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL word_seq: %0d bad accesses want 0", bad); else n_pass++;
    n_checks++;
    if (log_q.size() < 4 || {log_q[3].adr, log_q[3].dat} !== {20'h01006, 16'hA5A8})
      $display("FAIL word_last_write: size %0d want adr 01006 dat a5a8", log_q.size());
    else n_pass++;
    n_checks++; if ({done, fail, tmo, aborted, busy, err_cnt} !== {5'b10000, 16'h0})
      $display("FAIL word_status: got %b err %h want 10000 err 0", {done, fail, tmo, aborted, busy}, err_cnt); else n_pass++;
    n_checks++; if (gap_bad !== 0 || unstable !== 0 || stb_rises !== 8)
      $display("FAIL word_strobe: gap_bad %0d unstable %0d rises %0d want 0 0 8", gap_bad, unstable, stb_rises); else n_pass++;
  endtask

  task automatic test_byte_pass;
    bit ok; int bad;
    logic [15:0] wexp [3];
    logic [15:0] rexp [3];
    wexp = '{16'h007F, 16'h0080, 16'h0081};
    rexp = '{16'h007F, 16'hFF80, 16'hFF81};
    lat_max = 1;
    kick(20'h20001, 16'd3, 1'b1, 16'h007F);
    wait_done(200, ok);
    bad = (log_q.size() == 6) ? 0 : 99;
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      if (log_q[i].adr !== 20'h20001 + 20'(i % 3) || log_q[i].bm !== 1'b1 || log_q[i].we !== (i < 3) ||
          log_q[i].dat !== ((i < 3) ? wexp[i] : rexp[i - 3])) bad++;
    end
    n_checks++; if (!ok || bad !== 0) $display("FAIL byte_seq: done %b bad %0d want 1 0", ok, bad); else n_pass++;
    n_checks++; if ({done, fail, err_cnt} !== {2'b10, 16'h0}) $display("FAIL byte_status: done,fail %b err %h want 10 0", {done, fail}, err_cnt); else n_pass++;
  endtask

  task automatic test_corrupt;
    bit ok;
    lat_max = 2; corrupt_rd = 2;
    kick(20'h01000, 16'd4, 1'b0, 16'hA5A5);
    wait_done(200, ok);
    corrupt_rd = -1;
    n_checks++; if ({ok, done, fail, err_cnt} !== {3'b111, 16'd1}) $display("FAIL corrupt_flags: done,fail %b err %h want 11 1", {ok, done, fail}, err_cnt); else n_pass++;
    n_checks++; if (fail_adr !== 20'h01004) $display("FAIL corrupt_adr: got %h want 01004", fail_adr); else n_pass++;
    n_checks++; if ({fail_exp, fail_got} !== {16'hA5A7, 16'h0000}) $display("FAIL corrupt_data: exp %h got %h want a5a7 0000", fail_exp, fail_got); else n_pass++;
  endtask

  task automatic test_timeout;
    bit ok;
    silent = 1'b1;
    kick(20'h00400, 16'd4, 1'b0, 16'h1111);
    wait_done(600, ok);
    silent = 1'b0;
    n_checks++; if (hi_max !== 255) $display("FAIL tmo_stb_len: got %0d want 255", hi_max); else n_pass++;
    n_checks++; if ({ok, tmo, done, fail, aborted, bus.stb_o} !== 6'b111000) $display("FAIL tmo_flags: got %b want 111000", {ok, tmo, done, fail, aborted, bus.stb_o}); else n_pass++;
    n_checks++; if (err_cnt !== 16'h0 || log_q.size() !== 0) $display("FAIL tmo_err: err %h txns %0d want 0 0", err_cnt, log_q.size()); else n_pass++;
  endtask

  task automatic test_len0;
    kick(20'h00100, 16'd0, 1'b0, 16'h0);
    n_checks++; if ({done, busy} !== 2'b01) $display("FAIL len0_n1: done,busy %b want 01", {done, busy}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({done, busy} !== 2'b10) $display("FAIL len0_n2: done,busy %b want 10", {done, busy}); else n_pass++;
    n_checks++; if (stb_rises !== 0) $display("FAIL len0_stb: rises %0d want 0", stb_rises); else n_pass++;
  endtask

  task automatic test_wrap;
    bit ok;
    lat_max = 0;
    kick(20'hFFFFE, 16'd2, 1'b0, 16'h1234);
    wait_done(100, ok);
    n_checks++;
    if (!ok || log_q.size() != 4 || log_q[0].adr !== 20'hFFFFE || log_q[1].adr !== 20'h00000 ||
        log_q[2].adr !== 20'hFFFFE || log_q[3].adr !== 20'h00000)
      $display("FAIL wrap_adr: done %b txns %0d want FFFFE,00000 twice", ok, log_q.size());
    else n_pass++;
    n_checks++; if ({fail, err_cnt} !== 17'h0) $display("FAIL wrap_status: fail %b err %h want 0 0", fail, err_cnt); else n_pass++;
  endtask

  task automatic test_stop;
    bit ok;
    lat_max = 3;
    kick(20'h04000, 16'd8, 1'b0, 16'h2222);
    stop = 1'b1;
    wait_done(100, ok);
    stop = 1'b0;
    n_checks++; if (log_q.size() !== 1 || log_q[0].we !== 1'b1) $display("FAIL stop_txns: got %0d want 1 write", log_q.size()); else n_pass++;
    n_checks++; if ({ok, aborted, done, fail, tmo, busy} !== 6'b111000) $display("FAIL stop_flags: got %b want 111000", {ok, aborted, done, fail, tmo, busy}); else n_pass++;
  endtask

  task automatic test_start_busy;
    bit ok; int bad;
    lat_max = 1;
    kick(20'h03000, 16'd4, 1'b0, 16'h0100);
    repeat (3) @(negedge clk);
    base = 20'h50000; seed = 16'h9999; bm = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, ok);
    bad = (log_q.size() == 8) ? 0 : 99;
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      if (log_q[i].adr !== m_adr(20'h03000, 1'b0, i % 4) || log_q[i].bm !== 1'b0) bad++;
    n_checks++; if (!ok || bad !== 0) $display("FAIL busy_start_seq: done %b bad %0d want 1 0", ok, bad); else n_pass++;
    n_checks++; if ({fail, aborted, err_cnt} !== 18'h0) $display("FAIL busy_start_status: fail,abort %b err %h want 00 0", {fail, aborted}, err_cnt); else n_pass++;
  endtask

  task automatic test_random;
    bit ok; int bad, l;
    logic [19:0] b; logic m; logic [15:0] s;
    for (int it = 0; it < 6; it++) begin
      b = 20'($urandom); l = $urandom_range(8, 1); m = 1'($urandom_range(1, 0)); s = 16'($urandom);
      lat_max = $urandom_range(3, 0);
      kick(b, 16'(l), m, s);
      wait_done(300, ok);
      n_checks++; if (!ok || log_q.size() !== 2 * l) $display("FAIL rnd%0d_count: done %b txns %0d want %0d", it, ok, log_q.size(), 2 * l); else n_pass++;
      bad = 0;
      for (int i = 0; i < log_q.size() && i < 2 * l; i++) begin
        if (log_q[i].we !== (i < l) || log_q[i].bm !== m || log_q[i].adr !== m_adr(b, m, i % l) ||
            log_q[i].dat !== ((i < l) ? m_wdat(s, m, i) : m_rexp(s, m, i - l))) bad++;
      end
      n_checks++; if (bad !== 0) $display("FAIL rnd%0d_seq: %0d bad (base %h len %0d mode %b seed %h)", it, bad, b, l, m, s); else n_pass++;
      n_checks++; if ({done, fail, tmo, aborted, err_cnt} !== {4'b1000, 16'h0}) $display("FAIL rnd%0d_status: got %b err %h want 1000 0", it, {done, fail, tmo, aborted}, err_cnt); else n_pass++;
      n_checks++; if (gap_bad !== 0 || unstable !== 0 || stb_rises !== 2 * l) $display("FAIL rnd%0d_strobe: gap_bad %0d unstable %0d rises %0d want 0 0 %0d", it, gap_bad, unstable, stb_rises, 2 * l); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    bit hit;
    lat_max = 1;
    kick(20'h08000, 16'd4, 1'b0, 16'h4444);
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.stb_o && !bus.we_o) begin hit = 1'b1; break; end
    end
    n_checks++; if (!hit) $display("FAIL rst_mid_reach: read strobe never seen"); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (all_out !== '0) $display("FAIL rst_mid_outputs: got %h want 0", all_out); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (all_out !== '0) $display("FAIL rst_mid_idle: got %h want 0", all_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_word_pass();
    test_byte_pass();
    test_corrupt();
    test_timeout();
    test_len0();
    test_wrap();
    test_stop();
    test_start_busy();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
